// File: rtl/button_debounce_repeat.sv
// Push-button conditioner: two-flop synchroniser, press/release debounce, and
// auto-repeat press strobes while the button stays held.
module button_debounce_repeat #(
    parameter int DB_CYCLES   = 100000,
    parameter int HOLD_CYCLES = 2500000,
    parameter int RPT_CYCLES  = 500000,
    parameter int CNT_W       = 22
) (
    input  logic clk_5MHz,
    input  logic rst,
    input  logic i_push_button,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_hold
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        REPEAT,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             btn_s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;

    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_push_button;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;
    assign cnt_d = cnt_q + 1'b1;

    // Every state change clears the counter, so each state times from zero
    // against its own terminal value; strobes default low for one-cycle width.
    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q <= PRESS_DB;
                        cnt_q   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q   <= PRESSED;
                        cnt_q     <= '0;
                        pressed_q <= 1'b1;
                        press_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state_q <= RELEASE_DB;
                        cnt_q   <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                REPEAT: begin
                    if (!btn_s) begin
                        state_q <= RELEASE_DB;
                        cnt_q   <= '0;
                    end else if (cnt_q == RPT_LAST) begin
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RELEASE_DB: begin
                    // A bounce back high resumes hold/repeat timing from scratch.
                    if (btn_s) begin
                        state_q <= long_q ? REPEAT : PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                        long_q    <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_pressed       = pressed_q;
    assign o_press_pulse   = press_q;
    assign o_release_pulse = release_q;
    assign o_long_hold     = long_q;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat: directed scenarios plus random bounce
// patterns, checked against a run-length / elapsed-time reference model.
module tb_button_debounce_repeat;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 8;
    localparam int CW   = 5;

    logic clk_5MHz = 1'b0;
    logic rst;
    logic i_push_button;
    logic o_pressed;
    logic o_press_pulse;
    logic o_release_pulse;
    logic o_long_hold;

    int checks = 0;
    int errors = 0;

    // Reference model: input delay line, debounced level, length of the
    // current disagreeing run, and edges elapsed since the last hold anchor.
    logic m_p1;
    logic m_p2;
    logic m_level;
    int   m_run;
    int   m_since;
    logic e_pressed;
    logic e_press;
    logic e_release;
    logic e_long;

    logic [3:0] obs;
    logic [3:0] expv;

    assign obs  = {o_pressed, o_press_pulse, o_release_pulse, o_long_hold};
    assign expv = {e_pressed, e_press, e_release, e_long};

    button_debounce_repeat #(
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(HOLD),
        .RPT_CYCLES (RPT),
        .CNT_W      (CW)
    ) dut (
        .clk_5MHz       (clk_5MHz),
        .rst            (rst),
        .i_push_button  (i_push_button),
        .o_pressed      (o_pressed),
        .o_press_pulse  (o_press_pulse),
        .o_release_pulse(o_release_pulse),
        .o_long_hold    (o_long_hold)
    );

    always #5 clk_5MHz = ~clk_5MHz;

    task automatic model_reset();
        m_p1      = 1'b0;
        m_p2      = 1'b0;
        m_level   = 1'b0;
        m_run     = 0;
        m_since   = 0;
        e_pressed = 1'b0;
        e_press   = 1'b0;
        e_release = 1'b0;
        e_long    = 1'b0;
    endtask

    // A level change is accepted once the synchronised input has disagreed
    // with the debounced level for DB+1 consecutive edges.
    task automatic model_edge(input logic in);
        logic s;
        s       = m_p2;
        m_p2    = m_p1;
        m_p1    = in;
        e_press   = 1'b0;
        e_release = 1'b0;
        if (s != m_level) begin
            m_run = m_run + 1;
            if (m_run == DB + 1) begin
                m_level = s;
                m_run   = 0;
                m_since = 0;
                if (s) begin
                    e_pressed = 1'b1;
                    e_press   = 1'b1;
                end else begin
                    e_pressed = 1'b0;
                    e_long    = 1'b0;
                    e_release = 1'b1;
                end
            end
        end else if (m_run > 0) begin
            m_run   = 0;
            m_since = 0;
        end else if (m_level) begin
            m_since = m_since + 1;
            if (!e_long && m_since == HOLD) begin
                e_press = 1'b1;
                e_long  = 1'b1;
                m_since = 0;
            end else if (e_long && m_since == RPT) begin
                e_press = 1'b1;
                m_since = 0;
            end
        end
    endtask

    task automatic tick(input logic v);
        i_push_button = v;
        @(posedge clk_5MHz);
        model_edge(v);
        @(negedge clk_5MHz);
    endtask

    task automatic applyStimulus(input logic v, input int n);
        for (int k = 0; k < n; k++) tick(v);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        i_push_button = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_initial: observed %b expected 0000", obs);
        end
        i_push_button = 1'b1;
        repeat (3) @(posedge clk_5MHz);
        @(negedge clk_5MHz);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_held: observed %b expected 0000", obs);
        end
        i_push_button = 1'b0;
        rst           = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL reset_idle edge %0d: observed %b expected %b", k, obs, expv);
            end
        end
    endtask

    task automatic test_clean_press();
        int np;
        int pe;
        int pl;
        int nr;
        int re;
        int lh;
        np = 0; pe = 0; pl = 0; nr = 0; re = 0; lh = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(1'b1);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL clean_press edge %0d: observed %b expected %b", k, obs, expv);
            end
            if (o_press_pulse) begin np++; pe = k; end
            if (o_pressed && pl == 0) pl = k;
            if (o_long_hold) lh = 1;
        end
        for (int k = 1; k <= 15; k++) begin
            tick(1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL clean_release edge %0d: observed %b expected %b", k, obs, expv);
            end
            if (o_release_pulse) begin nr++; re = k; end
            if (o_long_hold) lh = 1;
        end
        checks++;
        if (np !== 1 || pe !== DB + 3) begin
            errors++;
            $display("[TB] FAIL clean_press_edge: observed %0d pulses at edge %0d, expected 1 at %0d", np, pe, DB + 3);
        end
        checks++;
        if (pl !== DB + 3) begin
            errors++;
            $display("[TB] FAIL clean_pressed_level: observed edge %0d expected %0d", pl, DB + 3);
        end
        checks++;
        if (nr !== 1 || re !== DB + 3) begin
            errors++;
            $display("[TB] FAIL clean_release_edge: observed %0d pulses at edge %0d, expected 1 at %0d", nr, re, DB + 3);
        end
        checks++;
        if (lh !== 0) begin
            errors++;
            $display("[TB] FAIL clean_long_hold: observed %0d expected 0", lh);
        end
    endtask

    task automatic test_bounce();
        int np;
        int pe;
        np = 0; pe = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                tick(k < 2 ? 1'b1 : 1'b0);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL bounce_toggle r%0d k%0d: observed %b expected %b", r, k, obs, expv);
                end
                if (o_press_pulse) np++;
            end
        end
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL bounce_settle edge %0d: observed %b expected %b", k, obs, expv);
            end
            if (o_press_pulse) begin np++; pe = k; end
        end
        checks++;
        if (np !== 1 || pe !== DB + 3) begin
            errors++;
            $display("[TB] FAIL bounce_single: observed %0d pulses at edge %0d, expected 1 at %0d", np, pe, DB + 3);
        end
        applyStimulus(1'b0, 12);
    endtask

    task automatic test_hold();
        int got[$];
        int want[$];
        int lh;
        int t;
        lh = 0;
        t  = DB + 3;
        want.push_back(t);
        t = t + HOLD;
        while (t <= 80) begin
            want.push_back(t);
            t = t + RPT;
        end
        for (int k = 1; k <= 80; k++) begin
            tick(1'b1);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL hold edge %0d: observed %b expected %b", k, obs, expv);
            end
            if (o_press_pulse) got.push_back(k);
            if (o_long_hold && lh == 0) lh = k;
        end
        checks++;
        if (got.size() !== want.size()) begin
            errors++;
            $display("[TB] FAIL hold_pulse_count: observed %0d expected %0d", got.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("[TB] FAIL hold_pulse_%0d: observed edge %0d expected %0d", i, got[i], want[i]);
                end
            end
        end
        checks++;
        if (lh !== DB + 3 + HOLD) begin
            errors++;
            $display("[TB] FAIL hold_long_edge: observed %0d expected %0d", lh, DB + 3 + HOLD);
        end
        applyStimulus(1'b0, 12);
    endtask

    task automatic test_release_glitch();
        int nr;
        int dropped;
        int first;
        nr = 0; dropped = 0; first = 0;
        applyStimulus(1'b1, 10);
        for (int k = 1; k <= 32; k++) begin
            tick(k <= 2 ? 1'b0 : 1'b1);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL glitch_pressed edge %0d: observed %b expected %b", k, obs, expv);
            end
            if (o_release_pulse) nr++;
            if (!o_pressed) dropped = 1;
            if (o_press_pulse && first == 0 && k > 2) first = k - 2;
        end
        checks++;
        if (nr !== 0 || dropped !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_no_release: observed releases %0d dropped %0d expected 0 0", nr, dropped);
        end
        checks++;
        if (first !== 3 + HOLD) begin
            errors++;
            $display("[TB] FAIL glitch_hold_restart: observed edge %0d expected %0d", first, 3 + HOLD);
        end
        applyStimulus(1'b0, 12);
    endtask

    task automatic test_short_glitches();
        logic [3:0] seen;
        seen = 4'b0000;
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 12; k++) begin
                tick(k < (g == 0 ? 1 : 3) ? 1'b1 : 1'b0);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL short_glitch g%0d k%0d: observed %b expected %b", g, k, obs, expv);
                end
                seen = seen | obs;
            end
        end
        checks++;
        if (seen !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL short_glitch_quiet: observed %b expected 0000", seen);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int np;
        int pe;
        np = 0; pe = 0;
        applyStimulus(1'b1, 40);
        checks++;
        if (o_long_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_setup_long: observed %b expected 1", o_long_hold);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rst_async_drop: observed %b expected 0000", obs);
        end
        repeat (2) @(posedge clk_5MHz);
        @(negedge clk_5MHz);
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick(1'b1);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL rst_repress edge %0d: observed %b expected %b", k, obs, expv);
            end
            if (o_press_pulse) begin np++; pe = k; end
        end
        checks++;
        if (np !== 1 || pe !== DB + 3) begin
            errors++;
            $display("[TB] FAIL rst_repress_pulse: observed %0d pulses at edge %0d, expected 1 at %0d", np, pe, DB + 3);
        end
        applyStimulus(1'b0, 12);
    endtask

    task automatic test_random();
        logic v;
        int   len;
        v = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            v   = ~v;
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                tick(v);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL random seg %0d k %0d: observed %b expected %b", seg, k, obs, expv);
                end
                checks++;
                if (o_press_pulse && o_release_pulse) begin
                    errors++;
                    $display("[TB] FAIL random_pulse_overlap seg %0d: observed both strobes, expected at most one", seg);
                end
            end
        end
        applyStimulus(1'b0, 12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_release_glitch();
        test_short_glitches();
        test_reset_mid_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
